// File: rtl/mips_dmem_responder.sv
// Data-memory slave for the single-cycle MIPS core: word RAM plus an MMIO window
// (GPIO, free-running cycle counter, console byte FIFO with host handshake).
module mips_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic [31:0] datamem_add,
    input  logic [31:0] write_data,
    output logic [31:0] datamem_readdata,
    output logic        addr_fault,
    output logic [31:0] gpio_out,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [27:0] MMIO_TAG  = MMIO_BASE[31:4];

    typedef enum logic [1:0] {
        REG_GPIO   = 2'd0,
        REG_CYCLE  = 2'd1,
        REG_CON_TX = 2'd2,
        REG_STATUS = 2'd3
    } mmio_reg_e;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic [31:0]   cycle_cnt;

    logic          ram_hit;
    logic          mmio_hit;
    logic          wr_en;
    logic [AW-1:0] word_idx;
    mmio_reg_e     reg_sel;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_req;
    logic          push;
    logic [31:0]   status_word;

    assign ram_hit    = datamem_add < RAM_BYTES;
    assign mmio_hit   = datamem_add[31:4] == MMIO_TAG;
    assign addr_fault = (datamem_add[1:0] != 2'b00) || !(ram_hit || mmio_hit);
    assign wr_en      = mem_write && !addr_fault;
    assign word_idx   = datamem_add[AW+1:2];
    assign reg_sel    = mmio_reg_e'(datamem_add[3:2]);

    assign full      = count == CW'(FIFO_DEPTH);
    assign empty     = count == '0;
    assign con_valid = !empty;
    assign con_data  = fifo_mem[rd_ptr];
    assign pop       = con_valid && con_ready;
    assign push_req  = wr_en && !ram_hit && (reg_sel == REG_CON_TX);
    // A pop in the same cycle frees the slot the push needs, even when full.
    assign push      = push_req && (!full || pop);

    assign status_word = {24'b0, 4'(count), 1'b0, ovf, full, empty};

    always_comb begin
        datamem_readdata = '0;
        if (!addr_fault) begin
            if (ram_hit) begin
                datamem_readdata = ram[word_idx];
            end else begin
                case (reg_sel)
                    REG_GPIO:   datamem_readdata = gpio_out;
                    REG_CYCLE:  datamem_readdata = cycle_cnt;
                    REG_CON_TX: datamem_readdata = '0;
                    REG_STATUS: datamem_readdata = status_word;
                    default:    datamem_readdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr_en && ram_hit) begin
            ram[word_idx] <= write_data;
        end
        if (rst && push) begin
            fifo_mem[wr_ptr] <= write_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_out  <= '0;
            cycle_cnt <= '0;
        end else begin
            if (wr_en && !ram_hit && reg_sel == REG_GPIO) begin
                gpio_out <= write_data;
            end
            if (wr_en && !ram_hit && reg_sel == REG_CYCLE) begin
                cycle_cnt <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && !push) begin
                ovf <= 1'b1;
            end else if (wr_en && !ram_hit && reg_sel == REG_STATUS) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
